fixed_point_div: RTL and testbench

Sequential sign-magnitude fixed-point divider. It is the inverse companion of the datapath's Q3.12 multiplier: it takes a dividend and a divisor in the same 16-bit sign-magnitude Q3.12 format and returns a Q3.12 quotient. The quotient can feed straight back into multiplier inputs. A restoring shift-subtract engine produces one quotient bit per clock and uses a start/done handshake.

---
 rtl/fixed_point_div_if.sv | 21 ++
 rtl/fixed_point_div.sv | 105 ++++++++++
 tb/tb_fixed_point_div.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fixed_point_div_if.sv
// Handshake and operand/result bundle for the Q3.12 sign-magnitude divider.
interface fixed_point_div_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic        overflow;
    logic        div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, overflow, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_point_div.sv
// Sequential restoring divider for 16-bit sign-magnitude Q3.12 operands.
// One quotient bit per clock over a 27-bit scaled dividend {|a|, 12'b0}.
module fixed_point_div (
    input  logic           clk,
    input  logic           rst,
    fixed_point_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic        sign;
    logic        zero_div;
    logic [14:0] divisor;
    logic [26:0] dividend;
    logic [26:0] quo_raw;
    logic [15:0] rem;

    logic [15:0] rem_shift;
    logic [15:0] rem_next;
    logic        q_bit;
    logic [26:0] quo_next;

    logic [15:0] quotient;
    logic        overflow;
    logic        div_by_zero;

    // Saturate the raw quotient to the 15-bit magnitude and suppress negative zero.
    function automatic logic [15:0] saturate_q(input logic s,
                                               input logic [26:0] raw,
                                               input logic force_max);
        logic [14:0] mag;
        mag = (force_max || (raw[26:15] != 12'd0)) ? 15'h7FFF : raw[14:0];
        return {s && (mag != 15'd0), mag};
    endfunction

    always_comb begin
        rem_shift = {rem[14:0], dividend[26]};
        q_bit     = (rem_shift >= {1'b0, divisor});
        rem_next  = q_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
        quo_next  = {quo_raw[25:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (count == 5'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A zero divisor still spends one CALC cycle so its done pulse lands one cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= 16'h0000;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign        <= bus.a[15] ^ bus.b[15];
                        divisor     <= bus.b[14:0];
                        dividend    <= {bus.a[14:0], 12'b0};
                        quo_raw     <= 27'd0;
                        rem         <= 16'd0;
                        zero_div    <= (bus.b[14:0] == 15'd0);
                        count       <= (bus.b[14:0] == 15'd0) ? 5'd0 : 5'd26;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    dividend <= {dividend[25:0], 1'b0};
                    rem      <= rem_next;
                    quo_raw  <= quo_next;
                    count    <= count - 5'd1;
                    if (count == 5'd0) begin
                        quotient    <= saturate_q(sign, quo_next, zero_div);
                        overflow    <= !zero_div && (quo_next[26:15] != 12'd0);
                        div_by_zero <= zero_div;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient;
    assign bus.overflow    = overflow;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_fixed_point_div.sv
// Directed bench for fixed_point_div: latency, sign/fraction, saturation, zero divisor, reset abort.
module tb_fixed_point_div;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fixed_point_div_if bus();

    fixed_point_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic [15:0] qexp, input logic ovf, input logic dz,
                           input int lexp);
        int lat;
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~av; bus.b = ~bv;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'(lexp));
        check({tag, " quotient"}, 32'(bus.quotient), 32'(qexp));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(ovf));
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(dz));
        @(posedge clk); #1;
        check({tag, " done low"}, 32'(bus.done), 32'd0);
        check({tag, " busy low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dones;
        int first;

        rst = 1'b1; bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quotient", 32'(bus.quotient), 32'h0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk); rst = 1'b0;

        run_div("basic", 16'h3000, 16'h1000, 16'h3000, 1'b0, 1'b0, 27);
        run_div("sign_frac", 16'h8800, 16'h2000, 16'h8400, 1'b0, 1'b0, 27);
        run_div("trunc", 16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b0, 27);

        repeat (3) @(posedge clk);
        #1;
        check("hold quotient", 32'(bus.quotient), 32'h0555);

        // Abort: reset asserted on edge k+15 of a running divide
        @(negedge clk);
        bus.a = 16'h7000; bus.b = 16'h0800; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
        end
        check("mid-calc quotient held", 32'(bus.quotient), 32'h0555);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort quotient", 32'(bus.quotient), 32'h0);
        check("abort overflow", 32'(bus.overflow), 32'd0);
        check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);

        run_div("after_abort", 16'h3000, 16'h1000, 16'h3000, 1'b0, 1'b0, 27);
        run_div("ovf_pos", 16'h7000, 16'h0800, 16'h7FFF, 1'b1, 1'b0, 27);
        run_div("ovf_neg", 16'h7000, 16'h8800, 16'hFFFF, 1'b1, 1'b0, 27);
        run_div("div_zero", 16'h1000, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1);
        run_div("back2back", 16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b0, 27);

        // Zero result, with a second start pulse at k+10 that must be ignored
        @(negedge clk);
        bus.a = 16'h8000; bus.b = 16'h1000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                if (first < 0) first = n;
            end
            if (n == 9) begin
                bus.a = 16'h3000; bus.b = 16'h1000; bus.start = 1'b1;
            end
            if (n == 10) bus.start = 1'b0;
        end
        check("ignored start done count", 32'(dones), 32'd1);
        check("ignored start latency", 32'(first), 32'd27);
        check("zero result quotient", 32'(bus.quotient), 32'h0000);
        check("zero result overflow", 32'(bus.overflow), 32'd0);
        check("zero result busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
